// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder.
// State encoding, latency counter width and latched operation codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W = 8;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/data_memory_responder_if.sv
// CPU data-port bus between the MEM stage (master) and the memory responder (slave).
// Signal suffixes are from the responder's point of view.
interface data_memory_responder_if #(
  parameter int DATA_W = 32
);
  logic              memRead_i;
  logic              memWrite_i;
  logic [31:0]       addr_i;
  logic [DATA_W-1:0] WriteData_i;
  logic [DATA_W-1:0] ReadData_o;
  logic              ack_o;
  logic              stall_o;
  logic              err_o;

  modport master (
    output memRead_i, memWrite_i, addr_i, WriteData_i,
    input  ReadData_o, ack_o, stall_o, err_o
  );

  modport slave (
    input  memRead_i, memWrite_i, addr_i, WriteData_i,
    output ReadData_o, ack_o, stall_o, err_o
  );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: synchronous write, registered read.
// Contents are never reset; only the read-data register clears on reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Read data holds its value until the next read completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data memory responder: accepts one request, stalls the pipeline,
// then pulses ack_o (and err_o for misaligned or read+write requests) LATENCY cycles later.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int LATENCY = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  data_memory_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              errf_q, errf_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  logic request;
  logic stall;
  logic enter_done;
  logic mem_we, mem_re;
  logic unused_addr_bits;

  assign request          = bus.memRead_i | bus.memWrite_i;
  assign unused_addr_bits = ^bus.addr_i[31:ADDR_W+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    errf_d  = errf_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = request;
        if (request) begin
          // Read+write together is resolved as a write and flagged.
          op_d    = bus.memWrite_i ? OP_WR : OP_RD;
          idx_d   = bus.addr_i[ADDR_W+1:2];
          wdata_d = bus.WriteData_i;
          errf_d  = (bus.addr_i[1:0] != 2'b00) | (bus.memRead_i & bus.memWrite_i);
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // op_d/idx_d/wdata_d already carry the live request when DONE is entered straight from IDLE.
  assign enter_done = (state_d == DONE) && (state_q != DONE);
  assign mem_we     = enter_done && (op_d == OP_WR);
  assign mem_re     = enter_done && (op_d == OP_RD);
  assign ack_d      = enter_done;
  assign err_d      = enter_done & errf_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      idx_q   <= '0;
      wdata_q <= '0;
      errf_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      errf_q  <= errf_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (idx_d),
    .wdata_i (wdata_d),
    .rdata_o (bus.ReadData_o)
  );

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.stall_o = stall;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed and randomized checks of data_memory_responder at LATENCY=10 and LATENCY=1
// against a word-array reference model.
module tb_data_memory_responder;

  localparam int L     = 10;
  localparam int WORDS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_responder_if #(.DATA_W(32)) bus10 ();
  data_memory_responder_if #(.DATA_W(32)) bus1 ();

  data_memory_responder #(.DATA_W(32), .DEPTH(WORDS), .LATENCY(L)) dut10 (
    .clk_i (clk), .rst_i (rst), .bus (bus10)
  );
  data_memory_responder #(.DATA_W(32), .DEPTH(WORDS), .LATENCY(1)) dut1 (
    .clk_i (clk), .rst_i (rst), .bus (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_mem [WORDS];
  logic [31:0] last_rd = 32'h0;
  logic [31:0] rd_cap;
  int          last_stalls;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=10 instance, checked every cycle.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int   idx;
    logic exp_err;
    int   stalls;
    idx     = int'((addr >> 2) % WORDS);
    exp_err = ((addr % 4) != 0) || (rd && wr);
    @(posedge clk); #1;
    bus10.memRead_i = rd; bus10.memWrite_i = wr; bus10.addr_i = addr; bus10.WriteData_i = data;
    stalls = 0;
    for (int k = 0; k < L; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      #1;
      check("stall_wait", 32'(bus10.stall_o), 32'd1);
      check("ack_wait", 32'(bus10.ack_o), 32'd0);
      check("rdata_hold", bus10.ReadData_o, last_rd);
      stalls += int'(bus10.stall_o);
    end
    @(posedge clk); #1;
    bus10.memRead_i = 1'b0; bus10.memWrite_i = 1'b0;
    #1;
    if (wr) model_mem[idx] = data;
    else    last_rd = model_mem[idx];
    check("ack_done", 32'(bus10.ack_o), 32'd1);
    check("stall_done", 32'(bus10.stall_o), 32'd0);
    check("err_done", 32'(bus10.err_o), 32'(exp_err));
    check("rdata_done", bus10.ReadData_o, last_rd);
    rd_cap      = bus10.ReadData_o;
    last_stalls = stalls;
    $display("txn rd=%0d wr=%0d addr=0x%08h wdata=0x%08h idx=%0d err=%0d rdata=0x%08h",
             rd, wr, addr, data, idx, bus10.err_o, bus10.ReadData_o);
    @(posedge clk); #2;
    check("ack_pulse_end", 32'(bus10.ack_o), 32'd0);
    check("err_pulse_end", 32'(bus10.err_o), 32'd0);
  endtask

  initial begin
    logic        r, w;
    logic [31:0] a, d;
    bus10.memRead_i = 0; bus10.memWrite_i = 0; bus10.addr_i = 0; bus10.WriteData_i = 0;
    bus1.memRead_i  = 0; bus1.memWrite_i  = 0; bus1.addr_i  = 0; bus1.WriteData_i  = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_ack", 32'(bus10.ack_o), 32'd0);
    check("rst_err", 32'(bus10.err_o), 32'd0);
    check("rst_stall", 32'(bus10.stall_o), 32'd0);
    check("rst_rdata", bus10.ReadData_o, 32'h0);
    check("rst_rdata_l1", bus1.ReadData_o, 32'h0);

    // LATENCY=1: single write, then a held read gives an ack every other cycle.
    @(posedge clk); #1;
    bus1.memWrite_i = 1; bus1.addr_i = 32'h4; bus1.WriteData_i = 32'hA5A5_0001;
    #1;
    check("l1_wr_stall", 32'(bus1.stall_o), 32'd1);
    check("l1_wr_ack0", 32'(bus1.ack_o), 32'd0);
    @(posedge clk); #1;
    bus1.memWrite_i = 0;
    #1;
    check("l1_wr_ack", 32'(bus1.ack_o), 32'd1);
    check("l1_wr_stall0", 32'(bus1.stall_o), 32'd0);
    $display("txn l1 write addr=0x00000004 wdata=0xa5a50001");
    @(posedge clk); #1;
    bus1.memRead_i = 1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      #1;
      check("l1_b2b_ack", 32'(bus1.ack_o), 32'(k % 2));
      check("l1_b2b_stall", 32'(bus1.stall_o), 32'((k % 2) == 0));
      if ((k % 2) == 1) begin
        check("l1_b2b_rdata", bus1.ReadData_o, 32'hA5A5_0001);
        $display("txn l1 read addr=0x00000004 rdata=0x%08h", bus1.ReadData_o);
      end
    end
    bus1.memRead_i = 0;

    // Give every word a known value.
    for (int i = 0; i < WORDS; i++) do_req(1'b0, 1'b1, 32'(i * 4), $urandom);

    // Write then read, followed by hold of read data across a write.
    do_req(1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'h8, 32'h0);
    check("wr_rd_value", rd_cap, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b1, 32'h10, 32'h0BAD_F00D);
    check("hold_after_wr", bus10.ReadData_o, 32'hDEAD_BEEF);

    // Address boundaries and read+write conflict.
    do_req(1'b0, 1'b1, 32'h80, 32'h1111_2222);
    do_req(1'b1, 1'b0, 32'h0, 32'h0);
    check("alias_0x80", rd_cap, 32'h1111_2222);
    do_req(1'b0, 1'b1, 32'h6, 32'h3333_4444);
    do_req(1'b1, 1'b0, 32'h4, 32'h0);
    check("misaligned_word1", rd_cap, 32'h3333_4444);
    do_req(1'b1, 1'b1, 32'h14, 32'h5555_6666);
    do_req(1'b1, 1'b0, 32'h14, 32'h0);
    check("rdwr_is_write", rd_cap, 32'h5555_6666);

    // Reset five cycles into a write: nothing committed, outputs cleared at once.
    @(posedge clk); #1;
    bus10.memWrite_i = 1; bus10.addr_i = 32'hC; bus10.WriteData_i = 32'h1234_5678;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_ack", 32'(bus10.ack_o), 32'd0);
    check("midrst_err", 32'(bus10.err_o), 32'd0);
    check("midrst_rdata", bus10.ReadData_o, 32'h0);
    bus10.memWrite_i = 0;
    #1;
    check("midrst_stall", 32'(bus10.stall_o), 32'd0);
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    do_req(1'b1, 1'b0, 32'hC, 32'h0);
    check("midrst_old_word", rd_cap, model_mem[3]);

    // lw r1,0x8 ; add r2,r1,r1
    do_req(1'b1, 1'b0, 32'h8, 32'h0);
    check("lw_stall_cycles", 32'(last_stalls), 32'(L));
    check("add_r2", rd_cap + rd_cap, 32'(model_mem[2] * 2));

    // Randomized mix of reads, writes, conflicts, misalignment and aliasing.
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!r && !w) r = 1'b1;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d = $urandom;
      do_req(r, w, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
